sprite_render_scheduler: RTL and testbench

- Initiator side of the sprite draw/erase handshake. Sprite blocks (player, aliens, bullets) are responders: they take draw_signal/erase_signal, stream x/y/colour, and pulse finish when an erase completes.
- This block sequences every client once per frame (draw all, hold for the frame tick, erase all, repeat).
- It muxes the active client's pixel stream onto the single VGA adapter write port and drives its plot enable.

---
 rtl/sprite_render_scheduler_pkg.sv | 32 +++
 rtl/sprite_render_scheduler_if.sv | 39 +++
 rtl/sprite_render_scheduler_pixel_mux_reg.sv | 41 ++++
 rtl/sprite_render_scheduler.sv | 159 +++++++++++++++
 tb/tb_sprite_render_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_render_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : render_pkg
// Brief    : Shared types, widths and helpers for the sprite render scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package render_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_DRAW  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERASE = 2'd3
    } state_t;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 3;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_render_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_render_scheduler_if
// Brief    : Client handshake, VGA write port and status flags of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_render_scheduler_if #(
    parameter int NUM_CLIENTS = 2
);
    import render_pkg::*;

    logic                            frame_tick;
    logic [X_W*NUM_CLIENTS-1:0]      client_x;
    logic [Y_W*NUM_CLIENTS-1:0]      client_y;
    logic [COLOUR_W*NUM_CLIENTS-1:0] client_colour;
    logic [NUM_CLIENTS-1:0]          client_finish;
    logic [NUM_CLIENTS-1:0]          draw_signal;
    logic [NUM_CLIENTS-1:0]          erase_signal;
    logic [X_W-1:0]                  vga_x;
    logic [Y_W-1:0]                  vga_y;
    logic [COLOUR_W-1:0]             vga_colour;
    logic                            plot;
    logic                            timeout_err;
    logic                            frame_overrun;

    modport master (
        input  frame_tick, client_x, client_y, client_colour, client_finish,
        output draw_signal, erase_signal, vga_x, vga_y, vga_colour, plot,
               timeout_err, frame_overrun
    );

    modport slave (
        output frame_tick, client_x, client_y, client_colour, client_finish,
        input  draw_signal, erase_signal, vga_x, vga_y, vga_colour, plot,
               timeout_err, frame_overrun
    );

endinterface
`default_nettype wire

// File: rtl/sprite_render_scheduler_pixel_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_mux_reg
// Brief    : Registered N-to-1 pixel mux of the client streams plus plot stage.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_mux_reg
    import render_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int SEL_W       = 1
) (
    input  wire                            clk,
    input  wire                            reset,
    input  wire [SEL_W-1:0]                sel,
    input  wire                            plot_req,
    input  wire [X_W*NUM_CLIENTS-1:0]      client_x,
    input  wire [Y_W*NUM_CLIENTS-1:0]      client_y,
    input  wire [COLOUR_W*NUM_CLIENTS-1:0] client_colour,
    output logic [X_W-1:0]                 vga_x,
    output logic [Y_W-1:0]                 vga_y,
    output logic [COLOUR_W-1:0]            vga_colour,
    output logic                           plot
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else begin
            vga_x      <= client_x[sel*X_W +: X_W];
            vga_y      <= client_y[sel*Y_W +: Y_W];
            vga_colour <= client_colour[sel*COLOUR_W +: COLOUR_W];
            plot       <= plot_req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_render_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_render_scheduler
// Brief    : Sequences draw/erase of every sprite client once per frame and
//            muxes the active client's pixel stream onto the VGA write port.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_render_scheduler
    import render_pkg::*;
#(
    parameter int NUM_CLIENTS   = 2,
    parameter int LEAD_CYCLES   = 3,
    parameter int DRAW_CYCLES   = 44,
    parameter int ERASE_TIMEOUT = 63
) (
    input  wire                         clk,
    input  wire                         reset,
    sprite_render_scheduler_if.master   bus
);

    localparam int SEL_W = clog2_min1(NUM_CLIENTS);
    localparam int CNT_W = $clog2(max_int(DRAW_CYCLES, ERASE_TIMEOUT) + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(max_int(DRAW_CYCLES, ERASE_TIMEOUT));
    localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LEAD       = CNT_W'(LEAD_CYCLES);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_CLIENTS - 1);

    state_t                 r_state, w_state_nxt;
    logic [SEL_W-1:0]       r_sel, w_sel_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                   r_gap, w_gap_nxt;
    logic                   r_tick_pending;
    logic                   r_timeout_err;
    logic                   r_frame_overrun;
    logic                   w_consume;
    logic                   w_timeout_set;
    logic                   w_req_active;
    logic                   w_finish_sel;
    logic [NUM_CLIENTS-1:0] w_onehot;

    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_finish_sel = bus.client_finish[r_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_START;
            r_sel           <= '0;
            r_cnt           <= '0;
            r_gap           <= 1'b0;
            r_tick_pending  <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_frame_overrun <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_sel           <= w_sel_nxt;
            r_cnt           <= w_cnt_nxt;
            r_gap           <= w_gap_nxt;
            // A tick landing on the consuming cycle re-arms the pending flag.
            r_tick_pending  <= (r_tick_pending & ~w_consume) | bus.frame_tick;
            r_frame_overrun <= r_frame_overrun | (bus.frame_tick & r_tick_pending);
            r_timeout_err   <= r_timeout_err | w_timeout_set;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = 1'b0;
        w_consume     = 1'b0;
        w_timeout_set = 1'b0;
        w_req_active  = 1'b0;
        case (r_state)
            ST_START: begin
                w_sel_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                if (!r_gap) begin
                    w_req_active = 1'b1;
                    if (r_cnt == DRAW_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_sel == SEL_LAST) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_sel_nxt = r_sel + 1'b1;
                            w_gap_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            ST_HOLD: begin
                w_cnt_nxt = '0;
                if (r_tick_pending) begin
                    w_consume   = 1'b1;
                    w_sel_nxt   = '0;
                    w_state_nxt = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (!r_gap) begin
                    w_req_active = 1'b1;
                    if (w_finish_sel || r_cnt == ERASE_LAST) begin
                        w_cnt_nxt     = '0;
                        w_timeout_set = ~w_finish_sel;
                        if (r_sel == SEL_LAST) begin
                            w_sel_nxt   = '0;
                            w_state_nxt = ST_DRAW;
                        end else begin
                            w_sel_nxt = r_sel + 1'b1;
                            w_gap_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_onehot[i] = (r_sel == SEL_W'(i));
        end
    end

    assign bus.draw_signal   = (r_state == ST_DRAW  && w_req_active) ? w_onehot : '0;
    assign bus.erase_signal  = (r_state == ST_ERASE && w_req_active) ? w_onehot : '0;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.frame_overrun = r_frame_overrun;

    pixel_mux_reg #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .SEL_W       (SEL_W)
    ) u_pixel_mux (
        .clk           (clk),
        .reset         (reset),
        .sel           (r_sel),
        .plot_req      (w_req_active && (r_cnt >= LEAD)),
        .client_x      (bus.client_x),
        .client_y      (bus.client_y),
        .client_colour (bus.client_colour),
        .vga_x         (bus.vga_x),
        .vga_y         (bus.vga_y),
        .vga_colour    (bus.vga_colour),
        .plot          (bus.plot)
    );

endmodule
`default_nettype wire

// File: tb/tb_sprite_render_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_render_scheduler
// Brief    : Randomised self-checking bench with a schedule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_render_scheduler;

    localparam int NC    = 2;
    localparam int LEAD  = 3;
    localparam int DRAWC = 44;
    localparam int ETO   = 63;
    localparam int XALL  = 9 * NC;
    localparam int YALL  = 8 * NC;
    localparam int CALL  = 3 * NC;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sprite_render_scheduler_if #(.NUM_CLIENTS(NC)) bus ();

    sprite_render_scheduler #(
        .NUM_CLIENTS   (NC),
        .LEAD_CYCLES   (LEAD),
        .DRAW_CYCLES   (DRAWC),
        .ERASE_TIMEOUT (ETO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- client behaviour / stimulus ----------------
    int fin_delay [NC];
    int ecnt      [NC];
    bit rand_en     = 0;
    bit spurious_en = 0;

    initial begin
        bus.frame_tick    = 1'b0;
        bus.client_x      = '0;
        bus.client_y      = '0;
        bus.client_colour = '0;
        bus.client_finish = '0;
        for (int c = 0; c < NC; c++) begin
            fin_delay[c] = 42;
            ecnt[c]      = 0;
        end
    end

    always @(posedge clk) begin
        logic [NC-1:0] f;
        #3;
        f = '0;
        bus.client_x      = XALL'($urandom);
        bus.client_y      = YALL'($urandom);
        bus.client_colour = CALL'($urandom);
        for (int c = 0; c < NC; c++) begin
            if (bus.erase_signal[c]) begin
                if (ecnt[c] == 0 && rand_en) fin_delay[c] = $urandom_range(1, 75);
                ecnt[c]++;
                f[c] = (fin_delay[c] != 0) && (ecnt[c] == fin_delay[c]);
            end else begin
                ecnt[c] = 0;
                f[c]    = spurious_en && ($urandom_range(0, 3) == 0);
            end
        end
        bus.client_finish = f;
        if (rand_en) bus.frame_tick = ($urandom_range(0, 149) == 0);
    end

    // ---------------- reference model ----------------
    logic [NC-1:0] exp_draw, exp_erase;
    logic [19:0]   exp_vga;
    logic          exp_plot, exp_timeout, exp_overrun;
    logic [NC-1:0] fin_q;
    bit            tick_pend, abort;

    function automatic logic [NC-1:0] oh(input int c);
        logic [NC-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // One scheduler cycle: publish its requests, then absorb the edge ending it.
    task automatic cycle(input logic [NC-1:0] d, input logic [NC-1:0] e,
                         input bit preq, input int s, input bit consume);
        exp_draw  = d;
        exp_erase = e;
        @(posedge clk);
        if (reset) begin
            abort = 1;
            return;
        end
        fin_q    = bus.client_finish;
        exp_vga  = {bus.client_x[s*9 +: 9], bus.client_y[s*8 +: 8], bus.client_colour[s*3 +: 3]};
        exp_plot = preq;
        if (bus.frame_tick && tick_pend) exp_overrun = 1'b1;
        tick_pend = (tick_pend && !consume) || bus.frame_tick;
    endtask

    task automatic draw_round();
        for (int c = 0; c < NC; c++) begin
            if (c > 0) begin
                cycle('0, '0, 1'b0, c, 1'b0);
                if (abort) return;
            end
            for (int k = 0; k < DRAWC; k++) begin
                cycle(oh(c), '0, k >= LEAD, c, 1'b0);
                if (abort) return;
            end
        end
    endtask

    task automatic hold_phase();
        bit leave;
        forever begin
            leave = tick_pend;
            cycle('0, '0, 1'b0, NC - 1, leave);
            if (abort || leave) return;
        end
    endtask

    task automatic erase_round();
        for (int c = 0; c < NC; c++) begin
            if (c > 0) begin
                cycle('0, '0, 1'b0, c, 1'b0);
                if (abort) return;
            end
            for (int k = 0; k < ETO; k++) begin
                cycle('0, oh(c), k >= LEAD, c, 1'b0);
                if (abort) return;
                if (fin_q[c]) break;
                if (k == ETO - 1) exp_timeout = 1'b1;
            end
        end
    endtask

    initial begin : ref_model
        forever begin
            wait (reset == 1'b0);
            abort       = 0;
            tick_pend   = 0;
            exp_timeout = 1'b0;
            exp_overrun = 1'b0;
            exp_plot    = 1'b0;
            exp_vga     = '0;
            cycle('0, '0, 1'b0, 0, 1'b0);
            while (!abort) begin
                draw_round();
                if (!abort) hold_phase();
                if (!abort) erase_round();
            end
        end
    end

    // ---------------- continuous comparison ----------------
    bit check_en = 0;

    always @(negedge clk) begin
        if (check_en && !reset) begin
            check_eq("draw_signal",  32'(bus.draw_signal),  32'(exp_draw));
            check_eq("erase_signal", 32'(bus.erase_signal), 32'(exp_erase));
            check_eq("plot",         32'(bus.plot),         32'(exp_plot));
            check_eq("vga_xyc",      32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(exp_vga));
            check_eq("flags",        32'({bus.timeout_err, bus.frame_overrun}),
                                     32'({exp_timeout, exp_overrun}));
        end
    end

    // ---------------- directed sequence helpers ----------------
    task automatic tick_once();
        @(posedge clk); #3 bus.frame_tick = 1'b1;
        @(posedge clk); #3 bus.frame_tick = 1'b0;
    endtask

    task automatic wait_until(input string tag, input bit want_erase, input int budget);
        int  n   = 0;
        bit  hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            hit = want_erase ? (bus.erase_signal == oh(0)) : (bus.draw_signal == oh(0));
            n++;
        end
        if (!hit) check_eq({tag, "_wait_expired"}, 32'(0), 32'(1));
    endtask

    task automatic check_all_low(input string tag);
        check_eq({tag, "_draw"},    32'(bus.draw_signal),  32'(0));
        check_eq({tag, "_erase"},   32'(bus.erase_signal), 32'(0));
        check_eq({tag, "_plot"},    32'(bus.plot),         32'(0));
        check_eq({tag, "_timeout"}, 32'(bus.timeout_err),  32'(0));
        check_eq({tag, "_overrun"}, 32'(bus.frame_overrun), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_low("reset_state");
        check_eq("reset_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(0));
        @(posedge clk); #3 reset = 1'b0;
        check_en = 1;

        // Draw round with no tick, then sit in HOLD before releasing a frame.
        repeat (110) @(posedge clk);
        tick_once();
        wait_until("resume_draw", 1'b0, 300);

        // Client 1 never finishes its erase.
        fin_delay[1] = 0;
        repeat (100) @(posedge clk);
        tick_once();
        wait_until("draw_after_timeout", 1'b0, 300);
        check_eq("timeout_sticky", 32'(bus.timeout_err), 32'(1));

        // Two ticks during the draw of client 0.
        repeat (5) @(posedge clk);
        tick_once();
        repeat (9) @(posedge clk);
        tick_once();
        wait_until("overrun_erase", 1'b1, 200);
        check_eq("overrun_set", 32'(bus.frame_overrun), 32'(1));
        wait_until("overrun_redraw", 1'b0, 300);

        // Stray finishes from idle clients, then reset in the middle of an erase.
        fin_delay[1] = 42;
        spurious_en  = 1;
        repeat (120) @(posedge clk);
        tick_once();
        wait_until("erase_before_reset", 1'b1, 200);
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_all_low("async_reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Free-running random frames.
        rand_en = 1;
        repeat (4000) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
